// File: rtl/checker_pattern_gen.sv
// checker_pattern_gen: animated checkerboard colour-index source.
// Raster position in, registered 3-bit palette index out, one cycle of latency.
// The animation state (scroll offsets, colour phase, frame counter) only changes
// on frame_start, so a single frame never shows two different animation steps.
// Optional build macro CB_BORDER_EN: forces index 0 on the outermost visible
// rows and columns. The border does not scroll.
module checker_pattern_gen #(
    parameter int H_BITS    = 10,
    parameter int V_BITS    = 10,
    parameter int TILE_LOG2 = 5,
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [H_BITS-1:0] pix_x,
    input  logic [V_BITS-1:0] pix_y,
    input  logic              video_active,
    input  logic              frame_start,
    input  logic [1:0]        mode,
    input  logic [1:0]        speed,
    input  logic              pause,
    output logic [2:0]        color_index,
    output logic              pix_valid
);

    localparam logic [H_BITS-1:0] H_TILE_BIT = H_BITS'(1) << TILE_LOG2;
    localparam logic [V_BITS-1:0] V_TILE_BIT = V_BITS'(1) << TILE_LOG2;

    logic [H_BITS-1:0] x_off_q, x_off_d;
    logic [V_BITS-1:0] y_off_q, y_off_d;
    logic [2:0]        phase_q, phase_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [2:0]        color_q, color_d;
    logic              valid_q;

    logic              frame_upd;
    logic [H_BITS-1:0] step_x;
    logic [V_BITS-1:0] step_y;
    logic              par;
    logic              border;

    // Per-frame animation update; decisions use the incoming mode so that
    // mode changes take effect exactly at the frame boundary.
    always_comb begin
        x_off_d     = x_off_q;
        y_off_d     = y_off_q;
        phase_d     = phase_q;
        frame_cnt_d = frame_cnt_q;
        mode_d      = mode_q;
        frame_upd   = frame_start && ena && !pause;
        step_x      = H_BITS'(1) << speed;
        step_y      = V_BITS'(1) << speed;
        if (frame_upd) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            mode_d      = mode;
            case (mode)
                2'd1: x_off_d = x_off_q + step_x;
                2'd2: begin
                    x_off_d = x_off_q + step_x;
                    y_off_d = y_off_q + step_y;
                end
                2'd3: begin
                    if (frame_cnt_q[2:0] == 3'd7) begin
                        phase_d = (phase_q == 3'd6) ? '0 : phase_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel path: tile parity from the scrolled coordinates (sums wrap at the
    // operand width), then select phase or black.
    always_comb begin
        par = (|((pix_x + x_off_q) & H_TILE_BIT)) ^ (|((pix_y + y_off_q) & V_TILE_BIT));
`ifdef CB_BORDER_EN
        border = (pix_x == '0) || (pix_x == H_BITS'(H_ACTIVE - 1)) ||
                 (pix_y == '0) || (pix_y == V_BITS'(V_ACTIVE - 1));
`else
        border = 1'b0;
`endif
        color_d = 3'd7;
        if (video_active) begin
            if (border) begin
                color_d = '0;
            end else begin
                color_d = par ? phase_q : 3'd7;
            end
        end
    end

    // Animation state register; next-state logic already folds in ena and pause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_off_q     <= '0;
            y_off_q     <= '0;
            phase_q     <= '0;
            frame_cnt_q <= '0;
            mode_q      <= '0;
        end else begin
            x_off_q     <= x_off_d;
            y_off_q     <= y_off_d;
            phase_q     <= phase_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
        end
    end

    // Output registers; held while the design is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_q <= 3'd7;
            valid_q <= 1'b0;
        end else if (ena) begin
            color_q <= color_d;
            valid_q <= video_active;
        end
    end

    assign color_index = color_q;
    assign pix_valid   = valid_q;

endmodule

// File: tb/tb_checker_pattern_gen.sv
// Directed bench for checker_pattern_gen: reset values, static pattern, blanking,
// X and diagonal scrolling with wrap, colour cycling, pause, enable, mid-frame
// mode change, same-cycle frame_start/pixel, and the border option when built in.
module tb_checker_pattern_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       video_active;
    logic       frame_start;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       pause;
    logic [2:0] color_index;
    logic       pix_valid;

    int checks = 0;
    int errors = 0;

    checker_pattern_gen #(
        .H_BITS   (10),
        .V_BITS   (10),
        .TILE_LOG2(5),
        .H_ACTIVE (640),
        .V_ACTIVE (480)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .video_active(video_active),
        .frame_start (frame_start),
        .mode        (mode),
        .speed       (speed),
        .pause       (pause),
        .color_index (color_index),
        .pix_valid   (pix_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one pixel, then sample the registered result just after the edge.
    task automatic pix(input int x, input int y, input logic va);
        @(negedge clk);
        pix_x        = 10'(x);
        pix_y        = 10'(y);
        video_active = va;
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            video_active = 1'b0;
            frame_start  = 1'b1;
            @(negedge clk);
            frame_start  = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; pix_x = '0; pix_y = '0; video_active = 1'b0;
        frame_start = 1'b0; mode = 2'd0; speed = 2'd0; pause = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_color", color_index, 3'd7);
        chk("reset_valid", {2'b0, pix_valid}, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Static pattern, offsets zero, phase zero
        pix(1, 64, 1'b1);
        chk("static_even", color_index, 3'd7);
        chk("static_valid", {2'b0, pix_valid}, 3'd1);
        pix(32, 64, 1'b1);
        chk("static_odd", color_index, 3'd0);

        // Blanking
        pix(32, 64, 1'b0);
        chk("blank_color", color_index, 3'd7);
        chk("blank_valid", {2'b0, pix_valid}, 3'd0);

        // Scroll X by 1 px for 32 frames -> x_off = 32
        mode = 2'd1; speed = 2'd0;
        pulses(32);
        pix(1, 64, 1'b1);
        chk("scrollx_1_64", color_index, 3'd0);
        pix(32, 64, 1'b1);
        chk("scrollx_32_64", color_index, 3'd7);

        // Diagonal, 8 px/frame: 4 frames -> x_off 64, y_off 32
        mode = 2'd2; speed = 2'd3;
        pulses(4);
        pix(1, 0, 1'b1);
        chk("diag4_1_0", color_index, 3'd0);
        // 124 more -> +1024 total, both offsets wrap: x_off 32, y_off 0
        pulses(124);
        pix(1, 0, 1'b1);
        chk("diagwrap_1_0", color_index, 3'd0);
        pix(1, 32, 1'b1);
        chk("diagwrap_1_32", color_index, 3'd7);

        // Asynchronous reset mid-frame forces outputs immediately
        pix(32, 64, 1'b1);
        chk("pre_rst_valid", {2'b0, pix_valid}, 3'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_color", color_index, 3'd7);
        chk("async_rst_valid", {2'b0, pix_valid}, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pix(1, 64, 1'b1);
        chk("rst_offsets_zero", color_index, 3'd7);

        // Colour cycling: phase advances when pre-increment frame_cnt[2:0]==7
        mode = 2'd3;
        pulses(7);
        pix(32, 64, 1'b1);
        chk("cycle7_phase0", color_index, 3'd0);
        pulses(1);
        pix(32, 64, 1'b1);
        chk("cycle8_phase1", color_index, 3'd1);
        pix(1, 64, 1'b1);
        chk("cycle8_even", color_index, 3'd7);

        pause = 1'b1;
        pulses(8);
        pix(32, 64, 1'b1);
        chk("pause_hold", color_index, 3'd1);
        pause = 1'b0;

        ena = 1'b0;
        pulses(8);
        pix(1, 64, 1'b1);
        chk("ena0_out_hold", color_index, 3'd1);
        ena = 1'b1;
        pix(32, 64, 1'b1);
        chk("ena0_phase_hold", color_index, 3'd1);

        // 48 more frames -> 6 advances 1..6 then wrap to 0
        pulses(48);
        pix(32, 64, 1'b1);
        chk("cycle56_wrap", color_index, 3'd0);
        pulses(8);
        pix(32, 64, 1'b1);
        chk("cycle64_phase1", color_index, 3'd1);

        // Non-cycling mode holds phase
        mode = 2'd0;
        pulses(8);
        pix(32, 64, 1'b1);
        chk("mode0_phase_hold", color_index, 3'd1);

        // Mode change without frame_start has no effect
        mode = 2'd1; speed = 2'd3;
        pix(1, 64, 1'b1);
        chk("midframe_mode", color_index, 3'd7);
        mode = 2'd0;
        pulses(1);
        pix(1, 64, 1'b1);
        chk("midframe_revert", color_index, 3'd7);

        // 4 frames at 8 px -> x_off 32
        mode = 2'd1;
        pulses(4);
        pix(1, 64, 1'b1);
        chk("scroll8_x32", color_index, 3'd1);

        // frame_start with a visible pixel: old offset for that pixel
        @(negedge clk);
        pix_x = 10'd25; pix_y = 10'd64; video_active = 1'b1; frame_start = 1'b1;
        @(posedge clk);
        #1;
        chk("same_cycle_old", color_index, 3'd1);
        @(negedge clk);
        frame_start = 1'b0;
        @(posedge clk);
        #1;
        chk("same_cycle_new", color_index, 3'd7);

`ifdef CB_BORDER_EN
        pix(639, 100, 1'b1);
        chk("border_right", color_index, 3'd0);
        pix(638, 100, 1'b1);
        chk("border_inside", color_index, 3'd7);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
